// File: rtl/cp0_except_if.sv
// Bus between the MEM/WB pipeline and the CP0 exception block.
// Carries exception inputs, mtc0/mfc0 access and resolved exception outputs.
interface cp0_except_if;
    logic        valid_i;
    logic [31:0] pc_i;
    logic        in_delayslot_i;
    logic [8:0]  except_i;
    logic [31:0] bad_addr_i;
    logic [5:0]  int_i;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic [31:0] excepttype_o;
    logic [31:0] cp0_epc_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic        timer_int_o;

    modport master (
        output valid_i, pc_i, in_delayslot_i, except_i, bad_addr_i, int_i,
        output we_i, waddr_i, wdata_i, raddr_i,
        input  rdata_o, excepttype_o, cp0_epc_o, status_o, cause_o, timer_int_o
    );

    modport slave (
        input  valid_i, pc_i, in_delayslot_i, except_i, bad_addr_i, int_i,
        input  we_i, waddr_i, wdata_i, raddr_i,
        output rdata_o, excepttype_o, cp0_epc_o, status_o, cause_o, timer_int_o
    );
endinterface

// File: rtl/cp0_except.sv
// MEM-stage exception resolver and CP0 register file
// (BadVAddr, Count, Compare, Status, Cause, EPC).
module cp0_except #(
    parameter logic [31:0] RESET_STATUS = 32'h00400000,
    parameter int          COUNT_DIV    = 2
) (
    input logic         clk,
    input logic         rst,
    cp0_except_if.slave bus
);
    localparam logic [4:0] R_BADV = 5'd8;
    localparam logic [4:0] R_COUNT = 5'd9;
    localparam logic [4:0] R_COMPARE = 5'd11;
    localparam logic [4:0] R_STATUS = 5'd12;
    localparam logic [4:0] R_CAUSE = 5'd13;
    localparam logic [4:0] R_EPC = 5'd14;
    localparam logic [31:0] STATUS_WMASK = 32'h0000ff03;
    localparam logic [31:0] CAUSE_WMASK = 32'h00000300;

    logic [31:0] badvaddr, count, compare, status, cause, epc;
    logic        phase, timer_int;

    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic [31:0] count_eff, compare_eff, status_eff, cause_eff, epc_eff;
    logic [31:0] count_next;
    logic        inc, int_pend, commit, eret, bad_wr;
    logic [4:0]  code;
    logic [8:0]  ex;

    assign ex = bus.except_i;

    assign wr_count   = bus.we_i && bus.waddr_i == R_COUNT;
    assign wr_compare = bus.we_i && bus.waddr_i == R_COMPARE;
    assign wr_status  = bus.we_i && bus.waddr_i == R_STATUS;
    assign wr_cause   = bus.we_i && bus.waddr_i == R_CAUSE;
    assign wr_epc     = bus.we_i && bus.waddr_i == R_EPC;

    // Same-cycle mtc0 values seen by every combinational decision
    assign count_eff   = wr_count ? bus.wdata_i : count;
    assign compare_eff = wr_compare ? bus.wdata_i : compare;
    assign status_eff  = wr_status ?
        ((status & ~STATUS_WMASK) | (bus.wdata_i & STATUS_WMASK)) : status;
    assign cause_eff   = wr_cause ?
        ((cause & ~CAUSE_WMASK) | (bus.wdata_i & CAUSE_WMASK)) : cause;
    assign epc_eff     = wr_epc ? bus.wdata_i : epc;

    assign int_pend = status_eff[0] && !status_eff[1] &&
                      |(cause_eff[15:8] & status_eff[15:8]);

    always_comb begin
        code = 5'h00;
        if (!rst && bus.valid_i) begin
            if (int_pend)   code = 5'h01;
            else if (ex[0]) code = 5'h04;
            else if (ex[1]) code = 5'h0a;
            else if (ex[2]) code = 5'h0c;
            else if (ex[3]) code = 5'h0d;
            else if (ex[4]) code = 5'h08;
            else if (ex[5]) code = 5'h09;
            else if (ex[6]) code = 5'h0e;
            else if (ex[7]) code = 5'h04;
            else if (ex[8]) code = 5'h05;
        end
    end

    assign eret   = code == 5'h0e;
    assign commit = code != 5'h00 && !eret;
    assign bad_wr = code == 5'h04 || code == 5'h05;

    assign inc        = (COUNT_DIV == 1) ? 1'b1 : phase;
    assign count_next = count + 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            badvaddr  <= '0;
            count     <= '0;
            compare   <= '0;
            status    <= RESET_STATUS;
            cause     <= '0;
            epc       <= '0;
            phase     <= 1'b0;
            timer_int <= 1'b0;
        end else begin
            phase <= (COUNT_DIV == 1) ? 1'b0 : ~phase;
            if (wr_count) begin
                count <= bus.wdata_i;
                phase <= 1'b0;
            end else if (inc) begin
                count <= count_next;
            end
            if (wr_compare) compare <= bus.wdata_i;
            if (wr_compare)
                timer_int <= 1'b0;
            else if (inc && !wr_count && count_next == compare)
                timer_int <= 1'b1;
            status <= status_eff;
            epc    <= epc_eff;
            cause  <= {cause_eff[31:16], bus.int_i[5] | timer_int,
                       bus.int_i[4:0], cause_eff[9:0]};
            // Exception fields override any same-cycle mtc0 value
            if (commit) begin
                if (!status_eff[1]) begin
                    epc <= bus.in_delayslot_i ? bus.pc_i - 32'd4 : bus.pc_i;
                    cause[31] <= bus.in_delayslot_i;
                end
                status[1]  <= 1'b1;
                cause[6:2] <= code;
                if (bad_wr) badvaddr <= ex[0] ? bus.pc_i : bus.bad_addr_i;
            end
            if (eret) status[1] <= 1'b0;
        end
    end

    always_comb begin
        case (bus.raddr_i)
            R_BADV:    bus.rdata_o = badvaddr;
            R_COUNT:   bus.rdata_o = count_eff;
            R_COMPARE: bus.rdata_o = compare_eff;
            R_STATUS:  bus.rdata_o = status_eff;
            R_CAUSE:   bus.rdata_o = cause_eff;
            R_EPC:     bus.rdata_o = epc_eff;
            default:   bus.rdata_o = 32'h0;
        endcase
    end

    assign bus.excepttype_o = {27'd0, code};
    assign bus.cp0_epc_o    = epc_eff;
    assign bus.status_o     = status;
    assign bus.cause_o      = cause;
    assign bus.timer_int_o  = timer_int;
endmodule
